// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard sequencer for a 5-stage RISC-V core.
// Decides one action per cycle (RUN / FREEZE / LDSTALL / FLUSH) and drives
// per-stage write-enables, IF/ID flush and ID/EX bubble combinationally.
// It tracks the load currently in EX and keeps saturating event counters.
module pipe_hazard_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       id_opcode,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_memread,
    input  logic             ex_br_valid,
    input  logic             ex_mispredict,
    input  logic             icache_stall,
    input  logic             dcache_stall,
    input  logic             cnt_clr,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_we,
    output logic             idex_bubble,
    output logic             exmem_we,
    output logic             memwb_we,
    output logic [1:0]       mode,
    output logic [CNT_W-1:0] ldstall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] freeze_cnt
);

    typedef enum logic [1:0] {
        ModeRun     = 2'd0,
        ModeFreeze  = 2'd1,
        ModeLdstall = 2'd2,
        ModeFlush   = 2'd3
    } mode_e;

    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJalr   = 7'b1100111;

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    logic       use_rs1;
    logic       use_rs2;
    logic       hz;
    mode_e      action;
    mode_e      mode_q;
    logic       ex_ld_q;
    logic [4:0] ex_rd_q;
    logic [CNT_W-1:0] ldstall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;
    logic [CNT_W-1:0] freeze_cnt_q;

    // Decode which source registers the ID instruction actually reads.
    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        unique case (id_opcode)
            OpReg, OpStore, OpBranch: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OpImm, OpLoad, OpJalr: begin
                use_rs1 = 1'b1;
            end
            default: begin
                use_rs1 = 1'b0;
                use_rs2 = 1'b0;
            end
        endcase
    end

    // x0 never creates a dependency, so a load to x0 cannot stall.
    assign hz = ex_ld_q && (ex_rd_q != 5'd0) &&
                ((use_rs1 && (id_rs1 == ex_rd_q)) || (use_rs2 && (id_rs2 == ex_rd_q)));

    // Pick exactly one action per cycle by priority and drive the stage controls.
    always_comb begin
        action      = ModeRun;
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        ifid_flush  = 1'b0;
        idex_we     = 1'b1;
        idex_bubble = 1'b0;
        exmem_we    = 1'b1;
        memwb_we    = 1'b1;
        if (icache_stall || dcache_stall) begin
            // EX is frozen, so a pending mispredict or hazard re-presents next cycle.
            action   = ModeFreeze;
            pc_we    = 1'b0;
            ifid_we  = 1'b0;
            idex_we  = 1'b0;
            exmem_we = 1'b0;
            memwb_we = 1'b0;
        end else if (ex_br_valid && ex_mispredict) begin
            // ID holds a wrong-path instruction, so any hazard on it is moot.
            action      = ModeFlush;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (hz) begin
            action      = ModeLdstall;
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    // EX load tracking, last-action register and saturating counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_ld_q       <= 1'b0;
            ex_rd_q       <= 5'd0;
            mode_q        <= ModeRun;
            ldstall_cnt_q <= '0;
            flush_cnt_q   <= '0;
            freeze_cnt_q  <= '0;
        end else begin
            if (idex_we) begin
                if (idex_bubble) begin
                    ex_ld_q <= 1'b0;
                    ex_rd_q <= 5'd0;
                end else begin
                    ex_ld_q <= id_memread;
                    ex_rd_q <= id_rd;
                end
            end

            mode_q <= action;

            if (cnt_clr) begin
                ldstall_cnt_q <= '0;
                flush_cnt_q   <= '0;
                freeze_cnt_q  <= '0;
            end else begin
                if ((action == ModeLdstall) && (ldstall_cnt_q != CntMax)) begin
                    ldstall_cnt_q <= ldstall_cnt_q + 1'b1;
                end
                if ((action == ModeFlush) && (flush_cnt_q != CntMax)) begin
                    flush_cnt_q <= flush_cnt_q + 1'b1;
                end
                if ((action == ModeFreeze) && (freeze_cnt_q != CntMax)) begin
                    freeze_cnt_q <= freeze_cnt_q + 1'b1;
                end
            end
        end
    end

    assign mode        = mode_q;
    assign ldstall_cnt = ldstall_cnt_q;
    assign flush_cnt   = flush_cnt_q;
    assign freeze_cnt  = freeze_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with 4-bit counters so saturation is reachable.
module tb_pipe_hazard_ctrl;

    localparam int unsigned CW = 4;

    // Packed control vector: {pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we, memwb_we}
    localparam logic [6:0] C_RUN     = 7'b1101011;
    localparam logic [6:0] C_FREEZE  = 7'b0000000;
    localparam logic [6:0] C_FLUSH   = 7'b1111111;
    localparam logic [6:0] C_LDSTALL = 7'b0001111;

    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [6:0]    id_opcode;
    logic [4:0]    id_rs1, id_rs2, id_rd;
    logic          id_memread;
    logic          ex_br_valid, ex_mispredict;
    logic          icache_stall, dcache_stall;
    logic          cnt_clr;
    logic          pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we, memwb_we;
    logic [1:0]    mode;
    logic [CW-1:0] ldstall_cnt, flush_cnt, freeze_cnt;
    logic [6:0]    ctl;

    int n_checks = 0;
    int n_err    = 0;

    pipe_hazard_ctrl #(.CNT_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_opcode    (id_opcode),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rd        (id_rd),
        .id_memread   (id_memread),
        .ex_br_valid  (ex_br_valid),
        .ex_mispredict(ex_mispredict),
        .icache_stall (icache_stall),
        .dcache_stall (dcache_stall),
        .cnt_clr      (cnt_clr),
        .pc_we        (pc_we),
        .ifid_we      (ifid_we),
        .ifid_flush   (ifid_flush),
        .idex_we      (idex_we),
        .idex_bubble  (idex_bubble),
        .exmem_we     (exmem_we),
        .memwb_we     (memwb_we),
        .mode         (mode),
        .ldstall_cnt  (ldstall_cnt),
        .flush_cnt    (flush_cnt),
        .freeze_cnt   (freeze_cnt)
    );

    assign ctl = {pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we, memwb_we};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_id(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic mr);
        id_opcode  = op;
        id_rs1     = rs1;
        id_rs2     = rs2;
        id_rd      = rd;
        id_memread = mr;
        #1;
    endtask

    // Advance past the next rising edge; inputs are then changed away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        ex_br_valid = 1'b0; ex_mispredict = 1'b0;
        icache_stall = 1'b0; dcache_stall = 1'b0; cnt_clr = 1'b0;
        set_id(OP_IMM, 5'd0, 5'd0, 5'd0, 1'b0);
        #1;
        chk("reset_ctl", {1'b0, ctl}, {1'b0, C_RUN});
        chk("reset_mode", {6'd0, mode}, 8'd0);
        chk("reset_ldcnt", {4'd0, ldstall_cnt}, 8'd0);
        chk("reset_flcnt", {4'd0, flush_cnt}, 8'd0);
        chk("reset_frcnt", {4'd0, freeze_cnt}, 8'd0);
        #9;
        rst_n = 1'b1;

        // 1: load-use stall lasts one cycle
        set_id(OP_LOAD, 5'd1, 5'd0, 5'd5, 1'b1);
        chk("t1_lw_run", {1'b0, ctl}, {1'b0, C_RUN});
        tick();
        set_id(OP_REG, 5'd5, 5'd1, 5'd6, 1'b0);
        chk("t1_stall", {1'b0, ctl}, {1'b0, C_LDSTALL});
        tick();
        chk("t1_after_run", {1'b0, ctl}, {1'b0, C_RUN});
        chk("t1_mode2", {6'd0, mode}, 8'd2);
        chk("t1_ldcnt", {4'd0, ldstall_cnt}, 8'd1);
        tick();
        chk("t1_mode0", {6'd0, mode}, 8'd0);

        // 2: x0 and operand-usage decode
        set_id(OP_LOAD, 5'd1, 5'd0, 5'd0, 1'b1);
        tick();
        set_id(OP_REG, 5'd0, 5'd0, 5'd6, 1'b0);
        chk("t2_x0_run", {1'b0, ctl}, {1'b0, C_RUN});
        tick();
        set_id(OP_LOAD, 5'd1, 5'd0, 5'd5, 1'b1);
        tick();
        set_id(OP_JAL, 5'd5, 5'd5, 5'd1, 1'b0);
        chk("t2_jal_run", {1'b0, ctl}, {1'b0, C_RUN});
        tick();
        set_id(OP_LOAD, 5'd1, 5'd0, 5'd5, 1'b1);
        tick();
        set_id(OP_JALR, 5'd1, 5'd5, 5'd1, 1'b0);
        chk("t2_jalr_rs2_run", {1'b0, ctl}, {1'b0, C_RUN});
        chk("t2_ldcnt_kept", {4'd0, ldstall_cnt}, 8'd1);
        tick();
        set_id(OP_LOAD, 5'd1, 5'd0, 5'd5, 1'b1);
        tick();
        set_id(OP_STORE, 5'd1, 5'd5, 5'd0, 1'b0);
        chk("t2_sw_rs2_stall", {1'b0, ctl}, {1'b0, C_LDSTALL});
        tick();
        chk("t2_sw_after_run", {1'b0, ctl}, {1'b0, C_RUN});
        chk("t2_ldcnt", {4'd0, ldstall_cnt}, 8'd2);
        tick();

        // 3: mispredict wins over a simultaneous load-use hazard
        set_id(OP_LOAD, 5'd1, 5'd0, 5'd5, 1'b1);
        tick();
        ex_br_valid = 1'b1; ex_mispredict = 1'b1;
        set_id(OP_REG, 5'd5, 5'd1, 5'd6, 1'b0);
        chk("t3_flush", {1'b0, ctl}, {1'b0, C_FLUSH});
        tick();
        ex_br_valid = 1'b0; ex_mispredict = 1'b0;
        #1;
        chk("t3_no_stall", {1'b0, ctl}, {1'b0, C_RUN});
        chk("t3_mode3", {6'd0, mode}, 8'd3);
        chk("t3_flcnt", {4'd0, flush_cnt}, 8'd1);
        chk("t3_ldcnt", {4'd0, ldstall_cnt}, 8'd2);
        ex_mispredict = 1'b1;
        #1;
        chk("t3_mispred_no_valid", {1'b0, ctl}, {1'b0, C_RUN});
        ex_mispredict = 1'b0;
        tick();

        // 4: freeze dominates a pending mispredict
        set_id(OP_IMM, 5'd0, 5'd0, 5'd0, 1'b0);
        ex_br_valid = 1'b1; ex_mispredict = 1'b1; dcache_stall = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("t4_freeze", {1'b0, ctl}, {1'b0, C_FREEZE});
            tick();
        end
        chk("t4_frcnt3", {4'd0, freeze_cnt}, 8'd3);
        chk("t4_mode1", {6'd0, mode}, 8'd1);
        dcache_stall = 1'b0;
        #1;
        chk("t4_flush", {1'b0, ctl}, {1'b0, C_FLUSH});
        tick();
        ex_br_valid = 1'b0; ex_mispredict = 1'b0;
        #1;
        chk("t4_flcnt2", {4'd0, flush_cnt}, 8'd2);
        chk("t4_frcnt_hold", {4'd0, freeze_cnt}, 8'd3);

        // 5: saturation at 15 and clear priority
        icache_stall = 1'b1;
        #1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 10) chk("t5_frcnt14", {4'd0, freeze_cnt}, 8'd14);
        end
        chk("t5_sat15", {4'd0, freeze_cnt}, 8'd15);
        cnt_clr = 1'b1;
        #1;
        chk("t5_clr_freeze", {1'b0, ctl}, {1'b0, C_FREEZE});
        tick();
        cnt_clr = 1'b0;
        #1;
        chk("t5_cleared", {4'd0, freeze_cnt}, 8'd0);
        chk("t5_fl_cleared", {4'd0, flush_cnt}, 8'd0);
        tick();
        chk("t5_count1", {4'd0, freeze_cnt}, 8'd1);
        icache_stall = 1'b0;

        // 6: dependent load chain stalls once each, then reset mid-stall
        set_id(OP_LOAD, 5'd1, 5'd0, 5'd5, 1'b1);
        tick();
        set_id(OP_LOAD, 5'd5, 5'd0, 5'd6, 1'b1);
        chk("t6_stall_a", {1'b0, ctl}, {1'b0, C_LDSTALL});
        tick();
        chk("t6_run_a", {1'b0, ctl}, {1'b0, C_RUN});
        tick();
        set_id(OP_REG, 5'd6, 5'd2, 5'd7, 1'b0);
        chk("t6_stall_b", {1'b0, ctl}, {1'b0, C_LDSTALL});
        chk("t6_ldcnt1", {4'd0, ldstall_cnt}, 8'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_ctl", {1'b0, ctl}, {1'b0, C_RUN});
        chk("t6_rst_mode", {6'd0, mode}, 8'd0);
        chk("t6_rst_ldcnt", {4'd0, ldstall_cnt}, 8'd0);
        chk("t6_rst_frcnt", {4'd0, freeze_cnt}, 8'd0);
        #1;
        rst_n = 1'b1;
        #1;
        chk("t6_rel_pc_we", {7'd0, pc_we}, 8'd1);
        tick();
        chk("t6_rel_mode", {6'd0, mode}, 8'd0);
        chk("t6_rel_ldcnt", {4'd0, ldstall_cnt}, 8'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline sequencer for the 5-stage RISC-V core (IF/ID/EX/MEM/WB).
- Produces per-stage write-enables, flushes and bubbles from four inputs: the ID-stage instruction fields and decoded control bits, EX-stage branch resolution, and I/D-cache stalls.
- Tracks the load currently in EX internally.
- Keeps saturating performance counters for stalls, flushes and freezes.

Parameters:
- CNT_W, 16, width of each performance counter.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- id_opcode  input  7  opcode of the instruction in ID
- id_rs1  input  5  rs1 field in ID
- id_rs2  input  5  rs2 field in ID
- id_rd  input  5  rd field in ID
- id_memread  input  1  decoded memread of the ID instruction
- ex_br_valid  input  1  EX holds a beq/bne/jal/jalr resolving this cycle
- ex_mispredict  input  1  EX resolution disagrees with the prediction; valid only with ex_br_valid
- icache_stall  input  1  instruction cache not ready
- dcache_stall  input  1  data cache not ready
- cnt_clr  input  1  synchronous clear of all counters
- pc_we  output  1  PC register update enable
- ifid_we  output  1  IF/ID write enable
- ifid_flush  output  1  IF/ID load NOP
- idex_we  output  1  ID/EX write enable
- idex_bubble  output  1  ID/EX load all-zero control
- exmem_we  output  1  EX/MEM write enable
- memwb_we  output  1  MEM/WB write enable
- mode  output  2  registered action of previous cycle: 0 RUN, 1 FREEZE, 2 LDSTALL, 3 FLUSH
- ldstall_cnt  output  CNT_W  load-use stall cycles
- flush_cnt  output  CNT_W  mispredict flushes
- freeze_cnt  output  CNT_W  cache freeze cycles

Behaviour:

Reset (rst_n low, asynchronous):
- mode=RUN.
- All counters 0.
- ex_ld_q=0, ex_rd_q=0.
- Combinational outputs then follow the rules below with the registers at their reset values.

Operand usage, decoded from id_opcode:
- use_rs1 = 1 for 0110011, 0010011, 0000011, 0100011, 1100011, 1100111.
- use_rs2 = 1 for 0110011, 0100011, 1100011.
- Any other opcode uses neither.

Load-use hazard:
- hz = ex_ld_q & (ex_rd_q != 0) & ((use_rs1 & id_rs1==ex_rd_q) | (use_rs2 & id_rs2==ex_rd_q)).

Action selection (combinational, priority order, exactly one per cycle):
1. FREEZE when icache_stall | dcache_stall.
   - All *_we=0, ifid_flush=0, idex_bubble=0.
   - ex_mispredict and hz are ignored; EX is frozen and they re-present next cycle.
2. FLUSH when ex_br_valid & ex_mispredict.
   - All *_we=1, ifid_flush=1, idex_bubble=1.
   - hz is ignored because ID holds a wrong-path instruction.
3. LDSTALL when hz.
   - pc_we=0, ifid_we=0, idex_we=1, idex_bubble=1, exmem_we=1, memwb_we=1, ifid_flush=0.
4. RUN otherwise.
   - All *_we=1, no flush, no bubble.

EX tracking registers (update on a rising edge only when idex_we=1):
- If idex_bubble: ex_ld_q<=0, ex_rd_q<=0.
- Else: ex_ld_q<=id_memread, ex_rd_q<=id_rd.
- A load-use stall therefore lasts exactly 1 cycle.
- Back-to-back dependent loads stall once each.

mode register:
- Each rising edge, mode<=action code of that cycle.
- Observational only; no output depends on it.

Counters:
- Each counter is saturating at all-ones; it never wraps.
- ldstall_cnt +1 per LDSTALL cycle.
- freeze_cnt +1 per FREEZE cycle.
- flush_cnt +1 per FLUSH cycle.
- cnt_clr has priority over increment in the same cycle; the counter reads 0 next cycle.

Reset mid-stall:
- All state clears immediately.
- The first cycle after release behaves as RUN unless the inputs force another action.

Outputs are combinational from inputs and registers. There is no added latency: an action takes effect at the same clock edge it is decided.

Test Plan:
1. Load-use stall:
   - Stimulus: ID lw x5 (id_memread=1, id_rd=5, RUN); next cycle ID add x6,x5,x1 (0110011, rs1=5).
   - Required: LDSTALL for 1 cycle (pc_we=0, idex_bubble=1), then RUN; ldstall_cnt=1; mode=2 then 0.
2. x0 and non-using opcodes:
   - Stimulus: lw x0 followed by add x6,x0,x0; then lw x5 followed by jal (1101111).
   - Required: no stall in either case; ldstall_cnt stays 0.
3. Mispredict with simultaneous hazard:
   - Stimulus: ex_br_valid=1, ex_mispredict=1 while hz=1.
   - Required: FLUSH (ifid_flush=1, idex_bubble=1, pc_we=1); flush_cnt=1; no LDSTALL next cycle.
4. Freeze over mispredict:
   - Stimulus: dcache_stall=1 for 3 cycles while ex_mispredict=1, then release.
   - Required: all *_we=0 for 3 cycles, then FLUSH once; freeze_cnt=3, flush_cnt=1.
5. Counter saturation and clear:
   - Stimulus: CNT_W=4; hold icache_stall for 20 cycles; then assert cnt_clr together with a stall.
   - Required: freeze_cnt saturates at 15; it reads 0 in the cycle after cnt_clr.
6. Asynchronous reset mid-stall:
   - Stimulus: rst_n low mid-cycle during LDSTALL.
   - Required: mode=0, counters=0, ex_ld_q cleared immediately without a clock edge; pc_we=1 after release.
